// File: rtl/permutator_pkg.sv
// Shared types and defaults for the slice permutation controller.
package permutator_pkg;

    localparam int LOG2SLICES_DEF = 3;
    localparam int LEN_W_DEF      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    typedef struct packed {
        logic [LOG2SLICES_DEF-1:0] mask;
        logic [LEN_W_DEF-1:0]      len;
    } cmd_t;

endpackage

// File: rtl/permutator_cmd_slot.sv
// One-entry valid/ready holding register for a pending burst command.
module permutator_cmd_slot #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = !r_valid;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_valid && !r_valid) begin
            r_valid <= 1'b1;
        end else if (i_ready && r_valid) begin
            r_valid <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed while r_valid is set.
    always_ff @(posedge clk) begin
        if (i_valid && !r_valid) begin
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/permutator_ctrl.sv
// Burst controller broadcasting an XOR slice permutation to a zero-latency datapath.
// Optional PERM_CMD_QUEUE_EN adds a pending command slot for gapless same-mask bursts.
module permutator_ctrl
    import permutator_pkg::*;
#(
    parameter int LOG2SLICES = LOG2SLICES_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LOG2SLICES-1:0] cmd_mask,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [LOG2SLICES-1:0] perm_cfg,
    output logic                  busy,
    output logic                  done
);

    state_t                r_state, w_state_nxt;
    logic [LEN_W-1:0]      r_cnt, w_cnt_nxt;
    logic [LOG2SLICES-1:0] r_perm_cfg, w_cfg_nxt;
    logic                  r_done, w_done_nxt;
    logic                  w_xfer;

`ifdef PERM_CMD_QUEUE_EN
    localparam int CW = LOG2SLICES + LEN_W;
    logic                  w_slot_ready, w_slot_valid, w_slot_push, w_slot_pop;
    logic [CW-1:0]         w_slot_data;
    logic [LOG2SLICES-1:0] w_slot_mask;
    logic [LEN_W-1:0]      w_slot_len;

    assign {w_slot_mask, w_slot_len} = w_slot_data;

    permutator_cmd_slot #(.W(CW)) u_slot (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_slot_push),
        .o_ready (w_slot_ready),
        .i_data  ({cmd_mask, cmd_len}),
        .o_valid (w_slot_valid),
        .i_ready (w_slot_pop),
        .o_data  (w_slot_data)
    );
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cfg_nxt   = r_perm_cfg;
        w_done_nxt  = 1'b0;
        w_xfer      = 1'b0;
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
`ifdef PERM_CMD_QUEUE_EN
        w_slot_push = 1'b0;
        w_slot_pop  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_cfg_nxt   = cmd_mask;
                    w_cnt_nxt   = cmd_len;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
`ifdef PERM_CMD_QUEUE_EN
                cmd_ready   = w_slot_ready;
                w_slot_push = cmd_valid && w_slot_ready;
`endif
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                out_valid = in_valid;
                in_ready  = out_ready;
                w_xfer    = in_valid && out_ready;
`ifdef PERM_CMD_QUEUE_EN
                cmd_ready   = w_slot_ready;
                w_slot_push = cmd_valid && w_slot_ready;
`endif
                if (w_xfer) begin
                    if (r_cnt == '0) begin
                        w_done_nxt = 1'b1;
`ifdef PERM_CMD_QUEUE_EN
                        // A command arriving on the final beat bypasses the slot.
                        if (w_slot_valid) begin
                            w_slot_pop  = 1'b1;
                            w_cfg_nxt   = w_slot_mask;
                            w_cnt_nxt   = w_slot_len;
                            w_state_nxt = (w_slot_mask == r_perm_cfg) ? ST_RUN : ST_SETTLE;
                        end else if (cmd_valid) begin
                            w_slot_push = 1'b0;
                            w_cfg_nxt   = cmd_mask;
                            w_cnt_nxt   = cmd_len;
                            w_state_nxt = (cmd_mask == r_perm_cfg) ? ST_RUN : ST_SETTLE;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
`else
                        w_state_nxt = ST_IDLE;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt - LEN_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_perm_cfg <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_perm_cfg <= w_cfg_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign out_last = (r_state == ST_RUN) && (r_cnt == '0);
    assign perm_cfg = r_perm_cfg;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;

endmodule

// File: tb/tb_permutator_ctrl.sv
// Directed testbench for permutator_ctrl; expected values are hand-computed per scenario.
module tb_permutator_ctrl;

    localparam int L2 = 3;
    localparam int LW = 8;
`ifdef PERM_CMD_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [L2-1:0] cmd_mask;
    logic [LW-1:0] cmd_len;
    logic          in_valid, in_ready, out_valid, out_ready, out_last;
    logic [L2-1:0] perm_cfg;
    logic          busy, done;

    int errors = 0;
    int checks = 0;

    permutator_ctrl #(.LOG2SLICES(L2), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mask  (cmd_mask),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .perm_cfg  (perm_cfg),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0; cmd_mask = '0; cmd_len = '0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick; tick;
        #1;
        checks++;
        if ({busy, done, out_last, perm_cfg, out_valid, in_ready} !== 8'b0) begin
            errors++;
            $display("FAIL reset_state: got %b want 00000000", {busy, done, out_last, perm_cfg, out_valid, in_ready});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
        tick;
    endtask

    task automatic test_basic;
        cmd_valid = 1'b1; cmd_mask = 3'b101; cmd_len = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, out_valid, in_ready, busy} !== 4'b1000) begin
            errors++; $display("FAIL basic_idle: got %b want 1000", {cmd_ready, out_valid, in_ready, busy});
        end
        tick;
        cmd_valid = 1'b0;
        #1;
        checks++;
        if ({perm_cfg, busy, out_valid, in_ready, cmd_ready, out_last} !== {3'd5, 1'b1, 1'b0, 1'b0, QEN, 1'b0}) begin
            errors++;
            $display("FAIL basic_settle: got %b want %b", {perm_cfg, busy, out_valid, in_ready, cmd_ready, out_last},
                     {3'd5, 1'b1, 1'b0, 1'b0, QEN, 1'b0});
        end
        tick;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({out_valid, in_ready, out_last, perm_cfg, done} !== {1'b1, 1'b1, (i == 3), 3'd5, 1'b0}) begin
                errors++;
                $display("FAIL basic_run%0d: got %b want %b", i, {out_valid, in_ready, out_last, perm_cfg, done},
                         {1'b1, 1'b1, (i == 3), 3'd5, 1'b0});
            end
            tick;
        end
        #1;
        checks++;
        if ({done, busy, out_valid, cmd_ready} !== 4'b1001) begin
            errors++; $display("FAIL basic_done: got %b want 1001", {done, busy, out_valid, cmd_ready});
        end
        tick;
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL basic_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_len0;
        cmd_valid = 1'b1; cmd_mask = 3'd2; cmd_len = 8'd0; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        cmd_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, perm_cfg} !== {1'b0, 3'd2}) begin
            errors++; $display("FAIL len0_settle: got %b want 0010", {out_valid, perm_cfg});
        end
        tick;
        #1;
        checks++;
        if ({out_valid, out_last} !== 2'b11) begin
            errors++; $display("FAIL len0_beat: got %b want 11", {out_valid, out_last});
        end
        tick;
        #1;
        checks++;
        if ({done, busy, cmd_ready, out_valid} !== 4'b1010) begin
            errors++; $display("FAIL len0_idle: got %b want 1010", {done, busy, cmd_ready, out_valid});
        end
        tick;
        #1;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++; $display("FAIL len0_after: got %b want 00", {done, busy});
        end
    endtask

    task automatic test_stall;
        int xfers;
        xfers = 0;
        cmd_valid = 1'b1; cmd_mask = 3'd3; cmd_len = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick;
        for (int i = 0; i < 15; i++) begin
            out_ready = (i % 2 == 0);
            #1;
            if (out_valid && out_ready) xfers++;
            checks++;
            if ({out_valid, in_ready, out_last, perm_cfg, busy} !== {1'b1, out_ready, (i >= 13), 3'd3, 1'b1}) begin
                errors++;
                $display("FAIL stall_run%0d: got %b want %b", i, {out_valid, in_ready, out_last, perm_cfg, busy},
                         {1'b1, out_ready, (i >= 13), 3'd3, 1'b1});
            end
            tick;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if ({done, busy} !== 2'b10 || xfers != 8) begin
            errors++; $display("FAIL stall_end: got done/busy=%b xfers=%0d want 10 xfers=8", {done, busy}, xfers);
        end
        tick;
    endtask

    task automatic test_rst_mid;
        cmd_valid = 1'b1; cmd_mask = 3'd6; cmd_len = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({out_valid, out_last, perm_cfg} !== {1'b1, 1'b0, 3'd6}) begin
                errors++; $display("FAIL rstmid_beat%0d: got %b want 106", i, {out_valid, out_last, perm_cfg});
            end
            tick;
        end
        rst = 1'b1;
        tick;
        #1;
        checks++;
        if ({busy, done, perm_cfg, out_valid} !== 6'b0) begin
            errors++; $display("FAIL rstmid_reset: got %b want 000000", {busy, done, perm_cfg, out_valid});
        end
        rst = 1'b0;
        cmd_valid = 1'b1; cmd_mask = 3'd2; cmd_len = 8'd1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_cmd_ready: got %b want 1", cmd_ready);
        end
        tick;
        cmd_valid = 1'b0;
        #1;
        checks++;
        if ({done, perm_cfg, out_valid} !== {1'b0, 3'd2, 1'b0}) begin
            errors++; $display("FAIL rstmid_settle: got %b want 00100", {done, perm_cfg, out_valid});
        end
        tick;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({out_valid, out_last, done} !== {1'b1, (i == 1), 1'b0}) begin
                errors++; $display("FAIL rstmid_new%0d: got %b want %b", i, {out_valid, out_last, done}, {1'b1, (i == 1), 1'b0});
            end
            tick;
        end
        #1;
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++; $display("FAIL rstmid_done: got %b want 10", {done, busy});
        end
        tick;
    endtask

    task automatic test_len_max;
        int xfers;
        int last_at;
        bit cfg_ok;
        xfers = 0; last_at = -1; cfg_ok = 1'b1;
        cmd_valid = 1'b1; cmd_mask = 3'd7; cmd_len = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick;
        for (int i = 0; i < 300 && last_at < 0; i++) begin
            #1;
            if (out_valid && out_ready) xfers++;
            if (perm_cfg !== 3'd7) cfg_ok = 1'b0;
            if (out_last === 1'b1) last_at = xfers;
            tick;
        end
        #1;
        checks++;
        if (last_at != 256 || !cfg_ok) begin
            errors++; $display("FAIL lenmax_beats: got last_at=%0d cfg_ok=%0d want 256 1", last_at, cfg_ok);
        end
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++; $display("FAIL lenmax_done: got %b want 10", {done, busy});
        end
        tick;
    endtask

`ifdef PERM_CMD_QUEUE_EN
    task automatic test_back_to_back;
        cmd_valid = 1'b1; cmd_mask = 3'd1; cmd_len = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_idle_ready: got %b want 1", cmd_ready);
        end
        tick;
        #1;
        checks++;
        if ({cmd_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL b2b_settle: got %b want 10", {cmd_ready, out_valid});
        end
        tick;
        cmd_mask = 3'd6; cmd_len = 8'd0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 6) cmd_valid = 1'b0;
            #1;
            checks++;
            if ({out_valid, in_ready, out_last, perm_cfg, cmd_ready, done} !==
                {1'b1, 1'b1, (i == 4 || i == 8), 3'd1, (i == 5), (i == 5)}) begin
                errors++;
                $display("FAIL b2b_run%0d: got %b want %b", i, {out_valid, in_ready, out_last, perm_cfg, cmd_ready, done},
                         {1'b1, 1'b1, (i == 4 || i == 8), 3'd1, (i == 5), (i == 5)});
            end
            tick;
        end
        #1;
        checks++;
        if ({out_valid, perm_cfg, done, busy} !== {1'b0, 3'd6, 1'b1, 1'b1}) begin
            errors++; $display("FAIL b2b_settle2: got %b want 011011", {out_valid, perm_cfg, done, busy});
        end
        tick;
        #1;
        checks++;
        if ({out_valid, out_last, perm_cfg} !== {1'b1, 1'b1, 3'd6}) begin
            errors++; $display("FAIL b2b_run3: got %b want 11110", {out_valid, out_last, perm_cfg});
        end
        tick;
        #1;
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++; $display("FAIL b2b_done3: got %b want 10", {done, busy});
        end
        tick;
    endtask
`else
    task automatic test_back_to_back;
        cmd_valid = 1'b1; cmd_mask = 3'd4; cmd_len = 8'd1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_idle_ready: got %b want 1", cmd_ready);
        end
        tick;
        cmd_mask = 3'd1; cmd_len = 8'd0;
        #1;
        checks++;
        if ({cmd_ready, perm_cfg} !== {1'b0, 3'd4}) begin
            errors++; $display("FAIL b2b_settle: got %b want 0100", {cmd_ready, perm_cfg});
        end
        tick;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({cmd_ready, out_valid, out_last} !== {1'b0, 1'b1, (i == 1)}) begin
                errors++; $display("FAIL b2b_run%0d: got %b want %b", i, {cmd_ready, out_valid, out_last}, {1'b0, 1'b1, (i == 1)});
            end
            tick;
        end
        #1;
        checks++;
        if ({cmd_ready, done, out_valid} !== 3'b110) begin
            errors++; $display("FAIL b2b_gap_idle: got %b want 110", {cmd_ready, done, out_valid});
        end
        tick;
        cmd_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, perm_cfg, busy} !== {1'b0, 3'd1, 1'b1}) begin
            errors++; $display("FAIL b2b_gap_settle: got %b want 00011", {out_valid, perm_cfg, busy});
        end
        tick;
        #1;
        checks++;
        if ({out_valid, out_last} !== 2'b11) begin
            errors++; $display("FAIL b2b_second: got %b want 11", {out_valid, out_last});
        end
        tick;
        #1;
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++; $display("FAIL b2b_done2: got %b want 10", {done, busy});
        end
        tick;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_basic;
        test_len0;
        test_stall;
        test_rst_mid;
        test_len_max;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
